// File: rtl/spi_rx.sv
// SPI slave receiver: synchronizes the serial clock/data lines, shifts in bytes
// MSB first on serial-clock rising edges, and discards partial bytes on timeout.
module spi_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       spi_clk,
  input  logic       spi_reset,
  input  logic       spi_input_data,
  input  logic       spi_input_clock,
  output logic [7:0] spi_data_out,
  output logic       spi_valid,
  output logic       spi_busy,
  output logic       spi_error
);

  typedef enum logic {
    IDLE,
    RECEIVE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic       din_s1_q, din_s2_q;
  logic       sck_s1_q, sck_s2_q, sck_dly_q;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       sck_rise;

  // Edges are only honoured once a real low level has passed through the
  // synchronizer, so a serial clock held high across reset is not an edge.
  assign fill_d   = {fill_q[0], 1'b1};
  assign armed_d  = armed_q | (fill_q[1] & ~sck_s2_q);
  assign sck_rise = armed_q & sck_s2_q & ~sck_dly_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sck_rise) begin
          shift_d   = {shift_q[5:0], din_s2_q};
          bit_cnt_d = 3'd1;
          tmo_d     = '0;
          state_d   = RECEIVE;
        end
      end
      RECEIVE: begin
        if (sck_rise) begin
          if (bit_cnt_q == 3'd7) begin
            // The eighth bit goes straight into the output, so seven
            // stored bits are enough.
            data_d    = {shift_q, din_s2_q};
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            shift_d   = {shift_q[5:0], din_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            tmo_d     = '0;
          end
        end else if (tmo_q == TMO_LAST) begin
          error_d   = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (spi_reset) begin
      din_s1_q  <= 1'b0;
      din_s2_q  <= 1'b0;
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_dly_q <= 1'b0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      din_s1_q  <= spi_input_data;
      din_s2_q  <= din_s1_q;
      sck_s1_q  <= spi_input_clock;
      sck_s2_q  <= sck_s1_q;
      sck_dly_q <= sck_s2_q;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign spi_data_out = data_q;
  assign spi_valid    = valid_q;
  assign spi_error    = error_q;
  assign spi_busy     = (state_q == RECEIVE);

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: stimulus pushes expected valid/error events,
// a monitor pops and compares them whenever the DUT pulses an output.
module tb_spi_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdi = 1'b0;
  logic       sck = 1'b0;
  logic [7:0] dout;
  logic       valid, busy, error;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_data = 8'h00;

  spi_rx #(.TIMEOUT_CYCLES(64)) dut (
    .spi_clk        (clk),
    .spi_reset      (rst),
    .spi_input_data (sdi),
    .spi_input_clock(sck),
    .spi_data_out   (dout),
    .spi_valid      (valid),
    .spi_busy       (busy),
    .spi_error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each bit: data set and clock low for lo cycles, then clock high for hi cycles.
  task automatic send_bits(input logic [7:0] d, input int n, input int lo, input int hi,
                           input bit chk_busy, input bit toggle);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      if (toggle) begin
        for (int k = 0; k < lo - 3; k++) begin
          sdi = ~sdi;
          cycles(1);
        end
        sdi = d[7-i];
        cycles(3);
      end else begin
        sdi = d[7-i];
        cycles(lo);
      end
      sck = 1'b1;
      cycles(hi);
      if (chk_busy) check($sformatf("busy_bit%0d", i), {7'b0, busy}, (i < 7) ? 8'h01 : 8'h00);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int half, input bit chk_busy, input bit toggle);
    push_byte(d);
    send_bits(d, 8, half, half, chk_busy, toggle);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid && error) check("valid_and_error", {valid, error}, 2'b00);
      if (valid || error) begin
        if (exp_q.size() == 0) begin
          check(valid ? "unexpected_valid" : "unexpected_error", {6'b0, valid, error}, 8'h00);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {7'b0, error}, {7'b0, e.is_err});
          if (!e.is_err) begin
            check("valid_data", dout, e.data);
            last_data = e.data;
          end else begin
            check("error_data_hold", dout, last_data);
          end
        end
      end
    end
  end

  initial begin : stim
    cycles(4);
    check("rst_data", dout, 8'h00);
    check("rst_flags", {5'b0, valid, busy, error}, 8'h00);
    rst = 1'b0;
    cycles(5);

    // Single byte with busy tracking
    check("busy_idle", {7'b0, busy}, 8'h00);
    send_byte(8'hA5, 7, 1'b1, 1'b0);
    cycles(10);
    check("data_a5", dout, 8'hA5);

    // Back-to-back bytes
    send_byte(8'h3C, 7, 1'b0, 1'b0);
    send_byte(8'hFF, 7, 1'b0, 1'b0);
    cycles(10);

    // Partial byte times out
    push_err();
    send_bits(8'hA0, 3, 7, 7, 1'b0, 1'b0);
    sck = 1'b0;
    cycles(80);
    check("tmo_busy", {7'b0, busy}, 8'h00);
    check("tmo_data_hold", dout, 8'hFF);
    send_byte(8'h81, 7, 1'b0, 1'b0);
    cycles(10);

    // Rising edges 64 clocks apart land on the timeout-terminal cycle
    send_byte(8'h96, 32, 1'b0, 1'b0);
    cycles(10);

    // 65 clocks apart: times out just before the second edge, which starts a new byte
    push_err();
    push_err();
    send_bits(8'hC0, 2, 33, 32, 1'b0, 1'b0);
    sck = 1'b0;
    cycles(80);
    check("tmo65_busy", {7'b0, busy}, 8'h00);

    // Reset mid-byte with serial clock left high across release
    send_bits(8'hF0, 5, 7, 7, 1'b0, 1'b0);
    rst = 1'b1;
    last_data = 8'h00;
    cycles(1);
    check("midrst_data", dout, 8'h00);
    check("midrst_flags", {5'b0, valid, busy, error}, 8'h00);
    cycles(2);
    rst = 1'b0;
    cycles(10);
    check("rst_high_sck_busy", {7'b0, busy}, 8'h00);
    send_byte(8'h0F, 7, 1'b0, 1'b0);
    cycles(10);
    check("data_0f", dout, 8'h0F);

    // Data toggling while serial clock low
    send_byte(8'h55, 8, 1'b0, 1'b1);
    cycles(100);
    check("data_55", dout, 8'h55);
    check("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
